param_update_arbiter: RTL and testbench
=======================================

Name: param_update_arbiter

Overview:
- Shares one WIDTH-bit parameter register (a feedback gain or offset feeding the pt_feedback datapath) between N_REQ requesters, for example the register bus, the sweep engine and the lock-in logic.
- Grants one requester at a time in round-robin order and loads its value into the shared register.
- Enforces a settle hold-off after each update so the downstream filter sees at most one parameter step per settle window.

Parameters:
- WIDTH, 16, parameter width in bits; values are signed two's complement.
- N_REQ, 4, number of requesters; must be 2 to 16.
- SETTLE_CYCLES, 16, hold-off cycles after each update; must be 2 or more.
- RESET_VALUE, 0, value of data_o after reset.
- STEP, 64, maximum change per cycle; used only when PARAM_ARB_RAMP_EN is defined.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  N_REQ  update request, one bit per requester; level, held until acked.
- data_i  in  N_REQ*WIDTH  requested values; requester k occupies bits [k*WIDTH +: WIDTH].
- ack_o  out  N_REQ  one-cycle grant acknowledge, one-hot.
- data_o  out  WIDTH  shared parameter register output.
- upd_o  out  1  one-cycle strobe: data_o has reached a new committed value.
- busy_o  out  1  high whenever the FSM is not in IDLE.
- grant_idx_o  out  $clog2(N_REQ)  index of the last granted requester.

Behaviour:
- All outputs are registered. Reset is asynchronous and active-high.
- Reset values: data_o=RESET_VALUE, ack_o=0, upd_o=0, busy_o=0, grant_idx_o=0, state=IDLE. The internal round-robin pointer last resets to N_REQ-1, so requester 0 wins first.
- Reset asserted mid-operation aborts immediately: no ack is issued and data_o returns to RESET_VALUE.
- IDLE: at a clock edge with req_i != 0, select g as the first set bit searching (last+1) mod N_REQ upward with wrap-around.
  - data_o <= data_i[g]; ack_o[g] <= 1; upd_o <= 1; grant_idx_o <= g; last <= g.
  - cnt <= SETTLE_CYCLES-1; state <= SETTLE.
  - Latency: request sampled at edge E0 appears on data_o, ack_o and upd_o in the cycle after E0.
- SETTLE: busy_o=1 and req_i is ignored.
  - Each edge: if cnt==0, go to IDLE; otherwise decrement cnt.
  - ack_o and upd_o are high for exactly one cycle.
- Throughput: consecutive grants are spaced exactly SETTLE_CYCLES+1 edges apart under continuous requests.
- Handshake rules:
  - A requester must keep req_i and its data stable until it sees ack_o, then deassert req_i within one cycle. SETTLE_CYCLES >= 2 guarantees the deassert lands before the next IDLE sample.
  - A req dropped before being granted has no effect.
  - Simultaneous requests are served strictly round-robin; no requester waits more than N_REQ grants.
- No arithmetic in the base mode. data_o is replaced verbatim, so wrap-around of the value cannot occur.

Optional Feature:
- Macro: PARAM_ARB_RAMP_EN.
- Defined:
  - A grant captures data_i[g] into target and asserts ack_o[g], but not upd_o. The FSM enters RAMP with busy_o=1.
  - Each cycle, diff = target - data_o, computed signed in WIDTH+1 bits (no overflow).
  - If |diff| <= STEP: data_o <= target, upd_o <= 1, cnt <= SETTLE_CYCLES-1, state <= SETTLE.
  - Otherwise data_o moves by +STEP or -STEP according to the sign of diff.
  - Requests are ignored during RAMP. Reset during RAMP behaves as any reset.
- Undefined: no RAMP state, STEP is unused, and data_o jumps in one cycle exactly as described in Behaviour.

Test Plan:
- Reset released, no requests -> data_o=RESET_VALUE, all strobes 0, busy_o=0 indefinitely.
- Only req_i[2] high with data 0x1234 -> one cycle later data_o=0x1234, ack_o=4'b0100, upd_o=1 for one cycle, grant_idx_o=2. busy_o stays high 16 cycles, then returns 0.
- req_i=4'b1111 held (each requester drops after its ack, re-raises 3 cycles later) -> grant order 0,1,2,3,0. Grants are spaced exactly 17 cycles apart.
- rst_i pulsed 5 cycles into SETTLE after writing 0x7FFF -> data_o=0 and busy_o=0 immediately; no ack appears. The next request gets requester 0 first.
- req_i[1] raised then dropped while requester 0 is in SETTLE -> requester 1 is never acked and data_o keeps requester 0's value.
- PARAM_ARB_RAMP_EN, STEP=64, data_o=0, request 200 -> data_o steps 64, 128, 192, then 200 with upd_o=1 only on the 200 cycle. A request of -100 from 200 steps 136, 72, 8, -56, then -100.

Source files
------------

// File: rtl/param_update_arbiter.sv
// param_update_arbiter
//   Shares one signed WIDTH-bit parameter register (gain/offset feeding the
//   pt_feedback datapath) between N_REQ requesters. Requests are granted one
//   at a time in round-robin order. After each committed update a settle
//   hold-off of SETTLE_CYCLES cycles keeps the downstream filter from seeing
//   more than one parameter step per settle window.
//
//   Optional feature (macro PARAM_ARB_RAMP_EN): instead of jumping, data_o
//   slews toward the granted value by at most STEP per cycle, and upd_o
//   fires only when the target is reached.
//
// Ports
//   clk_i        system clock
//   rst_i        asynchronous, active-high reset
//   req_i        per-requester update request (level, held until acked)
//   data_i       requested values, requester k at [k*WIDTH +: WIDTH]
//   ack_o        one-cycle, one-hot grant acknowledge
//   data_o       shared parameter register
//   upd_o        one-cycle strobe: data_o holds a newly committed value
//   busy_o       high whenever the FSM is not idle
//   grant_idx_o  index of the last granted requester
module param_update_arbiter #(
  parameter int                        WIDTH         = 16,
  parameter int                        N_REQ         = 4,
  parameter int                        SETTLE_CYCLES = 16,
  parameter logic signed [WIDTH-1:0]   RESET_VALUE   = '0,
  parameter int                        STEP          = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_REQ-1:0]             req_i,
  input  logic [N_REQ*WIDTH-1:0]       data_i,
  output logic [N_REQ-1:0]             ack_o,
  output logic signed [WIDTH-1:0]      data_o,
  output logic                         upd_o,
  output logic                         busy_o,
  output logic [$clog2(N_REQ)-1:0]     grant_idx_o
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(SETTLE_CYCLES);

  // Elaboration-time guard on the legal parameter ranges.
  generate
    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
      $error("param_update_arbiter: N_REQ must be 2..16");
    end
    if (SETTLE_CYCLES < 2) begin : g_bad_settle
      $error("param_update_arbiter: SETTLE_CYCLES must be >= 2");
    end
    if (STEP < 1) begin : g_bad_step
      $error("param_update_arbiter: STEP must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RAMP   = 2'd2
  } state_t;

  state_t                    state, state_n;
  logic [CNT_W-1:0]          cnt, cnt_n;
  logic [IDX_W-1:0]          last, last_n;
  logic signed [WIDTH-1:0]   data_n;
  logic [N_REQ-1:0]          ack_n;
  logic                      upd_n;
  logic                      busy_n;
  logic [IDX_W-1:0]          grant_n;

  // Unpacked view of the requester data bus.
  logic signed [WIDTH-1:0]   data_arr [N_REQ];

  genvar gk;
  generate
    for (gk = 0; gk < N_REQ; gk++) begin : g_unpack
      assign data_arr[gk] = data_i[gk*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin pick: first set request bit searching upward from last+1,
  // wrapping at N_REQ. The highest priority slot is the one after the
  // previous winner, so no requester waits more than N_REQ grants.
  logic                      found;
  logic [IDX_W-1:0]          g;
  int                        j;

  always_comb begin
    found = 1'b0;
    g     = '0;
    j     = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      j = int'(last) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req_i[IDX_W'(j)]) begin
        found = 1'b1;
        g     = IDX_W'(j);
      end
    end
  end

`ifdef PARAM_ARB_RAMP_EN
  localparam logic signed [WIDTH:0]   STEP_S = (WIDTH+1)'(STEP);
  localparam logic signed [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  logic signed [WIDTH-1:0] target, target_n;
  logic signed [WIDTH:0]   diff;
  logic                    ramp_done;

  // Move one STEP toward the target; the sign of the extended difference
  // chooses the direction. Only called when |diff| > STEP, so the result
  // stays strictly between data_o and target and cannot wrap.
  function automatic logic signed [WIDTH-1:0] ramp_next(
    input logic signed [WIDTH-1:0] cur,
    input logic signed [WIDTH:0]   d
  );
    return d[WIDTH] ? (cur - STEP_V) : (cur + STEP_V);
  endfunction

  // One extra bit makes target - data_o exact for any pair of WIDTH-bit values.
  always_comb begin
    diff      = {target[WIDTH-1], target} - {data_o[WIDTH-1], data_o};
    ramp_done = (diff <= STEP_S) && (diff >= -STEP_S);
  end
`endif

  // State register and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= IDX_W'(N_REQ-1);
      data_o      <= RESET_VALUE;
      ack_o       <= '0;
      upd_o       <= 1'b0;
      busy_o      <= 1'b0;
      grant_idx_o <= '0;
`ifdef PARAM_ARB_RAMP_EN
      target      <= RESET_VALUE;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      last        <= last_n;
      data_o      <= data_n;
      ack_o       <= ack_n;
      upd_o       <= upd_n;
      busy_o      <= busy_n;
      grant_idx_o <= grant_n;
`ifdef PARAM_ARB_RAMP_EN
      target      <= target_n;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (found) begin
`ifdef PARAM_ARB_RAMP_EN
          state_n = RAMP;
`else
          state_n = SETTLE;
          cnt_n   = CNT_W'(SETTLE_CYCLES-1);
`endif
        end
      end
      SETTLE: begin
        // Requests are not looked at here; the hold-off always runs out.
        if (cnt == '0) state_n = IDLE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
`ifdef PARAM_ARB_RAMP_EN
      RAMP: begin
        if (ramp_done) begin
          state_n = SETTLE;
          cnt_n   = CNT_W'(SETTLE_CYCLES-1);
        end
      end
`endif
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    data_n  = data_o;
    ack_n   = '0;
    upd_n   = 1'b0;
    grant_n = grant_idx_o;
    last_n  = last;
`ifdef PARAM_ARB_RAMP_EN
    target_n = target;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          ack_n[g] = 1'b1;
          grant_n  = g;
          last_n   = g;
`ifdef PARAM_ARB_RAMP_EN
          // Capture only; data_o starts moving on the following cycles.
          target_n = data_arr[g];
`else
          data_n   = data_arr[g];
          upd_n    = 1'b1;
`endif
        end
      end
`ifdef PARAM_ARB_RAMP_EN
      RAMP: begin
        if (ramp_done) begin
          data_n = target;
          upd_n  = 1'b1;
        end else begin
          data_n = ramp_next(data_o, diff);
        end
      end
`endif
      default: ;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_param_update_arbiter.sv
module tb_param_update_arbiter;

  localparam int W = 16;
  localparam int N = 4;
  localparam int S = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [N-1:0]         req_i;
  logic [N*W-1:0]       data_i;
  logic [N-1:0]         ack_o;
  logic signed [W-1:0]  data_o;
  logic                 upd_o;
  logic                 busy_o;
  logic [1:0]           grant_idx_o;

  param_update_arbiter #(
    .WIDTH(W), .N_REQ(N), .SETTLE_CYCLES(S), .RESET_VALUE('0), .STEP(64)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .data_i(data_i),
    .ack_o(ack_o), .data_o(data_o), .upd_o(upd_o), .busy_o(busy_o),
    .grant_idx_o(grant_idx_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int         idx;
    logic [W-1:0] data;
    int         gap;   // required spacing from previous grant, 0 = don't care
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int last_grant_cyc = 0;

  function automatic int u16(input logic [W-1:0] v);
    return int'(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever an ack is presented.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && ack_o != '0) begin
      if (q.size() == 0) begin
        check("unexpected_ack", int'(ack_o), 0);
      end else begin
        e = q.pop_front();
        check("ack_onehot", int'(ack_o), 1 << e.idx);
        check("grant_idx", int'(grant_idx_o), e.idx);
`ifdef PARAM_ARB_RAMP_EN
        check("upd_at_ack", int'(upd_o), 0);
`else
        check("grant_data", u16(data_o), u16(e.data));
        check("upd_at_ack", int'(upd_o), 1);
`endif
        if (e.gap != 0) check("grant_gap", cyc - last_grant_cyc, e.gap);
      end
      last_grant_cyc = cyc;
    end
`ifndef PARAM_ARB_RAMP_EN
    if (!rst_i && upd_o && ack_o == '0) check("stray_upd", int'(upd_o), 0);
`endif
  end

  task automatic wait_ack(input logic [1:0] k);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (ack_o[k]) return;
    end
    check("ack_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_i);
      if (!busy_o) return;
    end
    check("idle_timeout", 0, 1);
  endtask

  // Serve requests: drop on ack, optionally re-raise 3 cycles later.
  task automatic serve(input int n_acks, input bit reraise);
    int rel [N];
    int acks;
    logic [1:0] kk;
    acks = 0;
    for (int k = 0; k < N; k++) rel[k] = 0;
    for (int c = 0; c < 200 && acks < n_acks; c++) begin
      @(negedge clk_i);
      for (int k = 0; k < N; k++) begin
        kk = 2'(k);
        if (ack_o[kk]) begin
          req_i[kk] = 1'b0;
          rel[kk]   = reraise ? 3 : 0;
          acks++;
        end else if (rel[kk] > 0) begin
          rel[kk]--;
          if (rel[kk] == 0) req_i[kk] = 1'b1;
        end
      end
    end
    req_i = '0;
    check("serve_ack_count", acks, n_acks);
  endtask

`ifdef PARAM_ARB_RAMP_EN
  logic [W-1:0] ramp_up [4]   = '{16'd64, 16'd128, 16'd192, 16'd200};
  logic [W-1:0] ramp_dn [5]   = '{16'd136, 16'd72, 16'd8, 16'hFFC8, 16'hFF9C};
`endif

  initial begin
    rst_i  = 1'b1;
    req_i  = '0;
    data_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    // Idle after reset
    repeat (20) @(negedge clk_i);
    check("rst_data", u16(data_o), 0);
    check("rst_ack", int'(ack_o), 0);
    check("rst_upd", int'(upd_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_gidx", int'(grant_idx_o), 0);

`ifdef PARAM_ARB_RAMP_EN
    // Ramp up 0 -> 200
    data_i[0*W +: W] = 16'd200;
    q.push_back('{0, 16'd200, 0});
    req_i = 4'b0001;
    wait_ack(2'd0);
    req_i = '0;
    check("ramp_hold_at_ack", u16(data_o), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("ramp_up_data", u16(data_o), u16(ramp_up[i]));
      check("ramp_up_upd", int'(upd_o), (i == 3) ? 1 : 0);
    end
    wait_idle();

    // Ramp down 200 -> -100
    data_i[1*W +: W] = 16'hFF9C;
    q.push_back('{1, 16'hFF9C, 0});
    req_i = 4'b0010;
    wait_ack(2'd1);
    req_i = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("ramp_dn_data", u16(data_o), u16(ramp_dn[i]));
      check("ramp_dn_upd", int'(upd_o), (i == 4) ? 1 : 0);
    end
    wait_idle();
`else
    // Single request from requester 2
    data_i[2*W +: W] = 16'h1234;
    q.push_back('{2, 16'h1234, 0});
    req_i = 4'b0100;
    wait_ack(2'd2);
    req_i = '0;
    begin
      int nb;
      nb = busy_o ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk_i);
        if (busy_o) nb++;
        else break;
      end
      check("busy_len", nb, 16);
    end
    check("single_data_hold", u16(data_o), 16'h1234);
    check("single_gidx", int'(grant_idx_o), 2);

    // All four requesting continuously, fresh pointer
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i); rst_i = 1'b0;
    data_i = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    q.push_back('{0, 16'h0100, 0});
    q.push_back('{1, 16'h0101, 17});
    q.push_back('{2, 16'h0102, 17});
    q.push_back('{3, 16'h0103, 17});
    q.push_back('{0, 16'h0100, 17});
    req_i = 4'b1111;
    serve(5, 1'b1);
    wait_idle();

    // Reset in the middle of SETTLE
    data_i[0*W +: W] = 16'h7FFF;
    q.push_back('{0, 16'h7FFF, 0});
    req_i = 4'b0001;
    wait_ack(2'd0);
    req_i = '0;
    repeat (5) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("abort_data", u16(data_o), 0);
    check("abort_busy", int'(busy_o), 0);
    check("abort_ack", int'(ack_o), 0);
    check("abort_upd", int'(upd_o), 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    data_i[0*W +: W] = 16'hAAAA;
    data_i[2*W +: W] = 16'h5555;
    q.push_back('{0, 16'hAAAA, 0});
    q.push_back('{2, 16'h5555, 17});
    req_i = 4'b0101;
    serve(2, 1'b0);
    wait_idle();

    // Request dropped before being granted
    data_i[0*W +: W] = 16'h0BEE;
    q.push_back('{0, 16'h0BEE, 0});
    req_i = 4'b0001;
    wait_ack(2'd0);
    req_i = '0;
    repeat (3) @(negedge clk_i);
    data_i[1*W +: W] = 16'h0DEF;
    req_i = 4'b0010;
    repeat (4) @(negedge clk_i);
    req_i = '0;
    wait_idle();
    repeat (5) @(negedge clk_i);
    check("drop_data", u16(data_o), 16'h0BEE);
    check("drop_gidx", int'(grant_idx_o), 0);
    check("drop_busy", int'(busy_o), 0);
`endif

    check("scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
